// File: rtl/stack_cpu_core.sv
// ============================================================================
// Module   : stack_cpu_core
// Purpose  : 4-bit-opcode stack CPU with a scratch register, a data stack and
//            sticky fault detection. It fetches from a sync-read instruction memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_cpu_core #(
    parameter int   DATA_W      = 32,
    parameter int   IMEM_AW     = 11,
    parameter int   STACK_DEPTH = 16,
    parameter logic LED_INIT    = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    output logic [IMEM_AW-1:0]           imem_addr,
    input  logic [31:0]                  imem_data,
    output logic                         LED,
    output logic                         halted,
    output logic [1:0]                   fault,
    output logic [$clog2(STACK_DEPTH):0] sp_dbg,
    output logic [DATA_W-1:0]            scratch_dbg
);

    localparam int                 IDX_W   = $clog2(STACK_DEPTH);
    localparam int                 SP_W    = IDX_W + 1;
    localparam logic [SP_W-1:0]    SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]    SP_ONE  = SP_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
    localparam logic [IMEM_AW-1:0] PC_ONE  = IMEM_AW'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WAIT  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IMEM_AW-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                led_q, led_d;
    logic                halted_q, halted_d;
    logic [1:0]          fault_q, fault_d;
    logic [27:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   stack_q [STACK_DEPTH];

    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [IMEM_AW-1:0]  w_imm_pc;
    logic [IMEM_AW-1:0]  w_pc_inc;
    logic [IDX_W-1:0]    w_pop_idx;
    logic                w_push;

    assign w_op      = imem_data[31:28];
    assign w_imm_pc  = imem_data[IMEM_AW-1:0];
    assign w_pc_inc  = pc_q + PC_ONE;
    // Wraps to D-1 when sp==D, which is exactly the top entry of a full stack.
    assign w_pop_idx = sp_q[IDX_W-1:0] - IDX_ONE;

    // Immediate is zero-extended or truncated to the datapath width.
    if (DATA_W > 28) begin : g_imm_ext
        assign w_imm = {{(DATA_W-28){1'b0}}, imem_data[27:0]};
    end else if (DATA_W == 28) begin : g_imm_eq
        assign w_imm = imem_data[27:0];
    end else begin : g_imm_trunc
        assign w_imm = imem_data[DATA_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        scratch_d = scratch_q;
        sp_d      = sp_q;
        led_d     = led_q;
        halted_d  = halted_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        w_push    = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = w_pc_inc;
                case (w_op)
                    4'h0: ;
                    4'h1: begin
                        cnt_d   = imem_data[27:0];
                        state_d = S_WAIT;
                    end
                    4'h2: led_d = imem_data[0];
                    4'h3: pc_d = w_imm_pc;
                    4'h4: scratch_d = scratch_q - w_imm;
                    4'h5: if (scratch_q != '0) pc_d = pc_q - w_imm_pc;
                    4'h6: scratch_d = w_imm;
                    4'h7: begin
                        if (sp_q == '0) begin
                            fault_d[1] = 1'b1;
                            halted_d   = 1'b1;
                            pc_d       = pc_q;
                            state_d    = S_STOP;
                        end else begin
                            scratch_d = stack_q[w_pop_idx];
                            sp_d      = sp_q - SP_ONE;
                        end
                    end
                    4'h8: begin
                        if (sp_q == SP_FULL) begin
                            fault_d[0] = 1'b1;
                            halted_d   = 1'b1;
                            pc_d       = pc_q;
                            state_d    = S_STOP;
                        end else begin
                            w_push = 1'b1;
                            sp_d   = sp_q + SP_ONE;
                        end
                    end
                    4'h9: scratch_d = scratch_q + w_imm;
                    4'hA: if (scratch_q == '0) pc_d = pc_q + w_imm_pc;
                    4'hF: begin
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                        state_d  = S_STOP;
                    end
                    default: begin
                        fault_d[1] = 1'b1;
                        halted_d   = 1'b1;
                        pc_d       = pc_q;
                        state_d    = S_STOP;
                    end
                endcase
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - 28'd1;
            end
            S_STOP: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            scratch_q <= '0;
            sp_q      <= '0;
            led_q     <= LED_INIT;
            halted_q  <= 1'b0;
            fault_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            scratch_q <= scratch_d;
            sp_q      <= sp_d;
            led_q     <= led_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    // Stack storage is deliberately unreset.
    always_ff @(posedge CLK) begin
        if (w_push) stack_q[sp_q[IDX_W-1:0]] <= scratch_q;
    end

    assign imem_addr   = pc_q;
    assign LED         = led_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign sp_dbg      = sp_q;
    assign scratch_dbg = scratch_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_cpu_core.sv
// ============================================================================
// Module   : tb_stack_cpu_core
// Purpose  : Directed self-checking bench for stack_cpu_core (8-bit data,
//            32-word program, 4-entry stack).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stack_cpu_core;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int D  = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data = 32'h0;
    logic          LED;
    logic          halted;
    logic [1:0]    fault;
    logic [2:0]    sp_dbg;
    logic [DW-1:0] scratch_dbg;

    logic [31:0]   mem [32];
    int            n_vec = 0;
    int            n_bad = 0;

    stack_cpu_core #(
        .DATA_W      (DW),
        .IMEM_AW     (AW),
        .STACK_DEPTH (D),
        .LED_INIT    (1'b1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .LED         (LED),
        .halted      (halted),
        .fault       (fault),
        .sp_dbg      (sp_dbg),
        .scratch_dbg (scratch_dbg)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) imem_data <= mem[imem_addr];

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] imm);
        return {op, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = ins(4'hF, 28'h0);
    endtask

    // Leaves RST low just after a falling edge; tick(n) then observes state after n rising edges.
    task automatic restart();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (halted === 1'b1) ok = 1'b1;
            else @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_vec++; if (imem_addr !== 5'd0)    begin n_bad++; $display("FAIL rst_addr got %h exp 00", imem_addr); end
        n_vec++; if (LED !== 1'b1)          begin n_bad++; $display("FAIL rst_led got %b exp 1", LED); end
        n_vec++; if (halted !== 1'b0)       begin n_bad++; $display("FAIL rst_halted got %b exp 0", halted); end
        n_vec++; if (fault !== 2'b00)       begin n_bad++; $display("FAIL rst_fault got %b exp 00", fault); end
        n_vec++; if (sp_dbg !== 3'd0)       begin n_bad++; $display("FAIL rst_sp got %0d exp 0", sp_dbg); end
        n_vec++; if (scratch_dbg !== 8'h00) begin n_bad++; $display("FAIL rst_scratch got %h exp 00", scratch_dbg); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_push_pop();
        clear_mem();
        mem[0] = ins(4'h6, 28'd5);
        mem[1] = ins(4'h8, 28'd0);
        mem[2] = ins(4'h6, 28'd9);
        mem[3] = ins(4'h7, 28'd0);
        restart();
        tick(2);
        n_vec++; if (scratch_dbg !== 8'h05) begin n_bad++; $display("FAIL pp_ldi5 got %h exp 05", scratch_dbg); end
        tick(2);
        n_vec++; if (sp_dbg !== 3'd1)       begin n_bad++; $display("FAIL pp_push_sp got %0d exp 1", sp_dbg); end
        tick(2);
        n_vec++; if (scratch_dbg !== 8'h09) begin n_bad++; $display("FAIL pp_ldi9 got %h exp 09", scratch_dbg); end
        tick(2);
        n_vec++; if (scratch_dbg !== 8'h05) begin n_bad++; $display("FAIL pp_pop got %h exp 05", scratch_dbg); end
        n_vec++; if (sp_dbg !== 3'd0)       begin n_bad++; $display("FAIL pp_pop_sp got %0d exp 0", sp_dbg); end
        tick(2);
        n_vec++; if (halted !== 1'b1 || fault !== 2'b00 || imem_addr !== 5'd4)
            begin n_bad++; $display("FAIL pp_halt got h=%b f=%b pc=%0d exp h=1 f=00 pc=4", halted, fault, imem_addr); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mem();
        mem[0] = ins(4'h6, 28'hA1);
        mem[1] = ins(4'h8, 28'd0);
        mem[2] = ins(4'h6, 28'hB2);
        mem[3] = ins(4'h8, 28'd0);
        mem[4] = ins(4'h7, 28'd0);
        mem[5] = ins(4'h7, 28'd0);
        restart();
        tick(8);
        n_vec++; if (sp_dbg !== 3'd2)       begin n_bad++; $display("FAIL b2b_sp2 got %0d exp 2", sp_dbg); end
        tick(2);
        n_vec++; if (scratch_dbg !== 8'hB2) begin n_bad++; $display("FAIL b2b_pop1 got %h exp b2", scratch_dbg); end
        wait_halt(50, ok);
        n_vec++; if (!ok)                   begin n_bad++; $display("FAIL b2b_timeout got halted=%b exp 1", halted); end
        n_vec++; if (scratch_dbg !== 8'hA1 || sp_dbg !== 3'd0)
            begin n_bad++; $display("FAIL b2b_pop2 got %h sp=%0d exp a1 sp=0", scratch_dbg, sp_dbg); end
    endtask

    task automatic test_led_delay();
        clear_mem();
        mem[0] = ins(4'h2, 28'd0);
        mem[1] = ins(4'h2, 28'd1);
        mem[2] = ins(4'h1, 28'd10);
        mem[3] = ins(4'h2, 28'd0);
        restart();
        tick(2);
        n_vec++; if (LED !== 1'b0) begin n_bad++; $display("FAIL led_off got %b exp 0", LED); end
        tick(2);
        n_vec++; if (LED !== 1'b1) begin n_bad++; $display("FAIL led_on got %b exp 1", LED); end
        // DELAY 10 takes 13 cycles, then LED 0 takes 2 more before it commits.
        tick(14);
        n_vec++; if (LED !== 1'b1) begin n_bad++; $display("FAIL led_early got %b exp 1", LED); end
        tick(1);
        n_vec++; if (LED !== 1'b0) begin n_bad++; $display("FAIL led_late got %b exp 0", LED); end
    endtask

    task automatic test_loop();
        clear_mem();
        mem[0] = ins(4'h6, 28'd3);
        mem[1] = ins(4'h4, 28'd1);
        mem[2] = ins(4'h5, 28'd1);
        restart();
        // LDI(2) + 3 x (SUBI+JNZB)(4) + HALT(2) = 16 edges
        tick(15);
        n_vec++; if (halted !== 1'b0) begin n_bad++; $display("FAIL loop_early got %b exp 0", halted); end
        tick(1);
        n_vec++; if (halted !== 1'b1) begin n_bad++; $display("FAIL loop_halt got %b exp 1", halted); end
        n_vec++; if (scratch_dbg !== 8'h00 || imem_addr !== 5'd3 || fault !== 2'b00)
            begin n_bad++; $display("FAIL loop_state got s=%h pc=%0d f=%b exp s=00 pc=3 f=00", scratch_dbg, imem_addr, fault); end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_mem();
        mem[0] = ins(4'h6, 28'd7);
        for (int i = 1; i <= 5; i++) mem[i] = ins(4'h8, 28'd0);
        restart();
        wait_halt(100, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout got halted=%b exp 1", halted); end
        n_vec++; if (fault !== 2'b01 || sp_dbg !== 3'd4 || imem_addr !== 5'd5 || scratch_dbg !== 8'h07)
            begin n_bad++; $display("FAIL ovf_state got f=%b sp=%0d pc=%0d s=%h exp f=01 sp=4 pc=5 s=07", fault, sp_dbg, imem_addr, scratch_dbg); end
    endtask

    task automatic test_underflow();
        bit ok;
        clear_mem();
        mem[0] = ins(4'h6, 28'h33);
        mem[1] = ins(4'h7, 28'd0);
        restart();
        wait_halt(100, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL udf_timeout got halted=%b exp 1", halted); end
        n_vec++; if (fault !== 2'b10 || sp_dbg !== 3'd0 || imem_addr !== 5'd1 || scratch_dbg !== 8'h33)
            begin n_bad++; $display("FAIL udf_state got f=%b sp=%0d pc=%0d s=%h exp f=10 sp=0 pc=1 s=33", fault, sp_dbg, imem_addr, scratch_dbg); end
    endtask

    task automatic test_illegal();
        bit ok;
        clear_mem();
        mem[0] = ins(4'h2, 28'd0);
        mem[1] = ins(4'hC, 28'd0);
        mem[2] = ins(4'h2, 28'd1);
        restart();
        wait_halt(100, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL ill_timeout got halted=%b exp 1", halted); end
        tick(10);
        n_vec++; if (fault !== 2'b10 || halted !== 1'b1 || imem_addr !== 5'd1 || LED !== 1'b0)
            begin n_bad++; $display("FAIL ill_stop got f=%b h=%b pc=%0d led=%b exp f=10 h=1 pc=1 led=0", fault, halted, imem_addr, LED); end
    endtask

    task automatic test_branches();
        bit ok;
        clear_mem();
        mem[0] = ins(4'h6, 28'd0);
        mem[1] = ins(4'hA, 28'd3);
        mem[2] = ins(4'hB, 28'd0);
        mem[3] = ins(4'hB, 28'd0);
        mem[4] = ins(4'h4, 28'd1);
        mem[5] = ins(4'hA, 28'd2);
        mem[6] = ins(4'h5, 28'd8);
        restart();
        wait_halt(100, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL br_timeout got halted=%b exp 1", halted); end
        // JNZB 8 from pc 6 wraps to 30, which holds HALT.
        n_vec++; if (fault !== 2'b00 || imem_addr !== 5'd30 || scratch_dbg !== 8'hFF)
            begin n_bad++; $display("FAIL br_state got f=%b pc=%0d s=%h exp f=00 pc=30 s=ff", fault, imem_addr, scratch_dbg); end
    endtask

    task automatic test_width_wrap();
        clear_mem();
        mem[0]  = ins(4'h6, 28'h1FF);
        mem[1]  = ins(4'h9, 28'd1);
        mem[2]  = ins(4'h3, 28'h3E);
        mem[30] = ins(4'h9, 28'd5);
        mem[31] = ins(4'h0, 28'd0);
        restart();
        tick(2);
        n_vec++; if (scratch_dbg !== 8'hFF) begin n_bad++; $display("FAIL w_ldi got %h exp ff", scratch_dbg); end
        tick(2);
        n_vec++; if (scratch_dbg !== 8'h00) begin n_bad++; $display("FAIL w_addi got %h exp 00", scratch_dbg); end
        tick(2);
        n_vec++; if (imem_addr !== 5'd30)   begin n_bad++; $display("FAIL w_jmp got %0d exp 30", imem_addr); end
        tick(2);
        n_vec++; if (scratch_dbg !== 8'h05 || imem_addr !== 5'd31)
            begin n_bad++; $display("FAIL w_addi5 got s=%h pc=%0d exp s=05 pc=31", scratch_dbg, imem_addr); end
        tick(2);
        n_vec++; if (imem_addr !== 5'd0)    begin n_bad++; $display("FAIL w_pcwrap got %0d exp 0", imem_addr); end
    endtask

    task automatic test_reset_mid_delay();
        clear_mem();
        mem[0] = ins(4'h2, 28'd0);
        mem[1] = ins(4'h6, 28'h12);
        mem[2] = ins(4'h8, 28'd0);
        mem[3] = ins(4'h1, 28'd1000);
        restart();
        tick(20);
        n_vec++; if (LED !== 1'b0 || sp_dbg !== 3'd1 || imem_addr !== 5'd4)
            begin n_bad++; $display("FAIL rmd_pre got led=%b sp=%0d pc=%0d exp led=0 sp=1 pc=4", LED, sp_dbg, imem_addr); end
        #2;
        RST = 1'b1;
        #1;
        n_vec++; if (LED !== 1'b1 || sp_dbg !== 3'd0 || imem_addr !== 5'd0 || scratch_dbg !== 8'h00 || halted !== 1'b0 || fault !== 2'b00)
            begin n_bad++; $display("FAIL rmd_async got led=%b sp=%0d pc=%0d s=%h h=%b f=%b exp 1/0/0/00/0/00", LED, sp_dbg, imem_addr, scratch_dbg, halted, fault); end
        @(negedge CLK);
        RST = 1'b0;
        tick(2);
        n_vec++; if (LED !== 1'b0)          begin n_bad++; $display("FAIL rmd_refetch got led=%b exp 0", LED); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_push_pop();
        test_back_to_back();
        test_led_delay();
        test_loop();
        test_overflow();
        test_underflow();
        test_illegal();
        test_branches();
        test_width_wrap();
        test_reset_mid_delay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
